// File: rtl/cam_config_seq_if.sv
// Signal bundle between the camera config sequencer, its config ROM and the SCCB write master.
// The sequencer uses the master modport; the ROM/SCCB side uses the slave modport.
interface cam_config_seq_if;
  logic        i_start;
  logic [7:0]  o_rom_addr;
  logic [15:0] i_rom_data;
  logic        o_sccb_start;
  logic [7:0]  o_sccb_addr;
  logic [7:0]  o_sccb_data;
  logic        i_sccb_ready;
  logic        o_busy;
  logic        o_done;

  modport master (
    input  i_start, i_rom_data, i_sccb_ready,
    output o_rom_addr, o_sccb_start, o_sccb_addr, o_sccb_data, o_busy, o_done
  );

  modport slave (
    output i_start, i_rom_data, i_sccb_ready,
    input  o_rom_addr, o_sccb_start, o_sccb_addr, o_sccb_data, o_busy, o_done
  );
endinterface

// File: rtl/cam_config_seq.sv
// OV7670 configuration sequencer: walks the config ROM and issues one SCCB write per entry,
// honouring the settle-delay (FF_F0) and end-of-table (FF_FF) markers.
module cam_config_seq #(
  parameter int CLK_FREQ = 25_000_000,
  parameter int DELAY_MS = 10
) (
  input  logic             i_clk,
  input  logic             i_rst,
  cam_config_seq_if.master bus
);

  localparam logic [31:0] DELAY_CYCLES = 32'(CLK_FREQ / 1000 * DELAY_MS);
  localparam logic [31:0] DELAY_LAST   = DELAY_CYCLES - 32'd1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_REQ    = 3'd3,
    S_WAIT   = 3'd4,
    S_DELAY  = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t      state_r, state_s;
  logic [7:0]  rom_addr_r, rom_addr_s;
  logic [31:0] delay_cnt_r, delay_cnt_s;
  logic        sccb_start_r, sccb_start_s;
  logic [7:0]  sccb_addr_r, sccb_addr_s;
  logic [7:0]  sccb_data_r, sccb_data_s;
  logic        busy_r, busy_s;
  logic        done_r, done_s;
  logic        last_entry_s;

  function automatic logic is_end_marker(input logic [15:0] word);
    return (word == 16'hFFFF);
  endfunction

  function automatic logic is_delay_marker(input logic [15:0] word);
    return (word == 16'hFFF0);
  endfunction

  assign last_entry_s = (rom_addr_r == 8'hFF);

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    rom_addr_s   = rom_addr_r;
    delay_cnt_s  = delay_cnt_r;
    sccb_start_s = 1'b0;
    sccb_addr_s  = sccb_addr_r;
    sccb_data_s  = sccb_data_r;
    busy_s       = busy_r;
    done_s       = done_r;
    case (state_r)
      S_IDLE: begin
        rom_addr_s = 8'h00;
        if (bus.i_start) begin
          state_s = S_FETCH;
          busy_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: begin
        state_s = S_DECODE;
      end
      S_DECODE: begin
        if (is_end_marker(bus.i_rom_data)) begin
          state_s = S_DONE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else if (is_delay_marker(bus.i_rom_data)) begin
          delay_cnt_s = 32'd0;
          state_s     = S_DELAY;
        end else begin
          sccb_addr_s = bus.i_rom_data[15:8];
          sccb_data_s = bus.i_rom_data[7:0];
          state_s     = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.i_sccb_ready) begin
          sccb_start_s = 1'b1;
          state_s      = S_WAIT;
        end else begin
          state_s = S_REQ;
        end
      end
      // The start pulse is high exactly in the first WAIT cycle, where ready may still be stale.
      S_WAIT: begin
        if (!sccb_start_r && bus.i_sccb_ready) begin
          if (last_entry_s) begin
            state_s = S_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            rom_addr_s = rom_addr_r + 8'd1;
            state_s    = S_FETCH;
          end
        end else begin
          state_s = S_WAIT;
        end
      end
      S_DELAY: begin
        if (delay_cnt_r == DELAY_LAST) begin
          if (last_entry_s) begin
            state_s = S_DONE;
            busy_s  = 1'b0;
            done_s  = 1'b1;
          end else begin
            rom_addr_s = rom_addr_r + 8'd1;
            state_s    = S_FETCH;
          end
        end else begin
          delay_cnt_s = delay_cnt_r + 32'd1;
        end
      end
      S_DONE: begin
        if (bus.i_start) begin
          rom_addr_s = 8'h00;
          done_s     = 1'b0;
          busy_s     = 1'b1;
          state_s    = S_FETCH;
        end else begin
          state_s = S_DONE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r      <= S_IDLE;
      rom_addr_r   <= 8'h00;
      delay_cnt_r  <= 32'd0;
      sccb_start_r <= 1'b0;
      sccb_addr_r  <= 8'h00;
      sccb_data_r  <= 8'h00;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      rom_addr_r   <= rom_addr_s;
      delay_cnt_r  <= delay_cnt_s;
      sccb_start_r <= sccb_start_s;
      sccb_addr_r  <= sccb_addr_s;
      sccb_data_r  <= sccb_data_s;
      busy_r       <= busy_s;
      done_r       <= done_s;
    end
  end

  assign bus.o_rom_addr   = rom_addr_r;
  assign bus.o_sccb_start = sccb_start_r;
  assign bus.o_sccb_addr  = sccb_addr_r;
  assign bus.o_sccb_data  = sccb_data_r;
  assign bus.o_busy       = busy_r;
  assign bus.o_done       = done_r;

endmodule

// File: tb/tb_cam_config_seq.sv
// Directed bench for cam_config_seq: behavioural config ROM plus an SCCB master model
// that logs every write request.
module tb_cam_config_seq;
  localparam int WTIME = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cam_config_seq_if bus();

  cam_config_seq #(.CLK_FREQ(1000), .DELAY_MS(10)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  logic [15:0] rom [0:255];
  logic [15:0] rom_q = 16'h0000;
  int          cyc = 0;
  int          tests_run = 0;
  int          tests_failed = 0;

  logic        ready_m = 1'b1;
  logic        force_low = 1'b0;
  int          n_wr = 0;
  int          busy_cnt = 0;
  int          dbl_pulse = 0;
  int          unstable = 0;
  int          busy_gap = 0;
  logic        prev_start = 1'b0;
  logic        prev_busy = 1'b0;
  logic [7:0]  cur_addr = 8'h00;
  logic [7:0]  cur_data = 8'h00;
  logic [7:0]  log_addr [0:1023];
  logic [7:0]  log_data [0:1023];
  int          start_cyc [0:1023];
  int          rise_cyc [0:1023];
  logic [7:0]  exp_addr [0:255];
  logic [7:0]  exp_data [0:255];
  int          exp_n = 0;
  int          pass_base = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_q <= rom[bus.o_rom_addr];

  assign bus.i_rom_data   = rom_q;
  assign bus.i_sccb_ready = ready_m & ~force_low;

  // SCCB master model and write monitor
  always @(negedge clk) begin
    if (rst) begin
      ready_m    = 1'b1;
      busy_cnt   = 0;
      prev_start = 1'b0;
      prev_busy  = bus.o_busy;
    end else begin
      if (bus.o_sccb_start) begin
        if (prev_start) dbl_pulse++;
        if (n_wr < 1024) begin
          log_addr[n_wr]  = bus.o_sccb_addr;
          log_data[n_wr]  = bus.o_sccb_data;
          start_cyc[n_wr] = cyc;
          n_wr++;
        end
        cur_addr = bus.o_sccb_addr;
        cur_data = bus.o_sccb_data;
        ready_m  = 1'b0;
        busy_cnt = WTIME;
      end else if (busy_cnt > 0) begin
        if (bus.o_sccb_addr !== cur_addr || bus.o_sccb_data !== cur_data) unstable++;
        busy_cnt--;
        if (busy_cnt == 0) begin
          ready_m = 1'b1;
          rise_cyc[n_wr-1] = cyc;
        end
      end
      if (prev_busy && !bus.o_busy && !bus.o_done) busy_gap++;
      if (bus.o_busy && bus.o_done) busy_gap++;
      prev_start = bus.o_sccb_start;
      prev_busy  = bus.o_busy;
    end
  end

  task automatic load_std_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h1280;
    rom[1] = 16'hFFF0;
    for (int i = 2; i < 75; i++) rom[i] = {i[7:0] ^ 8'h3C, 8'(i * 7)};
    rom[10] = 16'hFF12;
    rom[11] = 16'h00AB;
    rom[75] = 16'h6906;
    rom[76] = 16'hFFFF;
  endtask

  task automatic build_expected();
    exp_n = 0;
    for (int i = 0; i < 256; i++) begin
      if (rom[i] == 16'hFFFF) break;
      if (rom[i] != 16'hFFF0) begin
        exp_addr[exp_n] = rom[i][15:8];
        exp_data[exp_n] = rom[i][7:0];
        exp_n++;
      end
    end
  endtask

  function automatic int seq_mismatches(input int base);
    int m = 0;
    for (int k = 0; k < exp_n; k++)
      if (log_addr[base+k] !== exp_addr[k] || log_data[base+k] !== exp_data[k]) m++;
    return m;
  endfunction

  task automatic pulse_start();
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_wr >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    bus.i_start = 1'b0;
    load_std_rom();
    build_expected();
    repeat (2) @(negedge clk);
    tests_run++;
    if (bus.o_rom_addr !== 8'h00) begin tests_failed++; $display("FAIL reset_rom_addr: got %0h want 0", bus.o_rom_addr); end
    tests_run++;
    if ({bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_sccb_addr, bus.o_sccb_data} !== 19'h0) begin
      tests_failed++; $display("FAIL reset_outputs: got %0h want 0", {bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_sccb_addr, bus.o_sccb_data});
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr} !== 11'h0) begin
      tests_failed++; $display("FAIL idle_outputs: got %0h want 0", {bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr});
    end
  endtask

  task automatic test_full_table();
    bit ok;
    int gap0;
    gap0 = busy_gap;
    pass_base = n_wr;
    pulse_start();
    wait_done(3000, ok);
    tests_run++;
    if (ok !== 1'b1) begin tests_failed++; $display("FAIL full_done_timeout: got done=0 want done=1"); end
    tests_run++;
    if (n_wr - pass_base !== 75) begin tests_failed++; $display("FAIL full_write_count: got %0d want 75", n_wr - pass_base); end
    tests_run++;
    if (seq_mismatches(pass_base) !== 0) begin tests_failed++; $display("FAIL full_order: got %0d mismatching writes want 0", seq_mismatches(pass_base)); end
    tests_run++;
    if ({log_addr[pass_base], log_data[pass_base]} !== 16'h1280) begin
      tests_failed++; $display("FAIL first_write: got %0h want 1280", {log_addr[pass_base], log_data[pass_base]});
    end
    tests_run++;
    if ({log_addr[pass_base+74], log_data[pass_base+74]} !== 16'h6906) begin
      tests_failed++; $display("FAIL last_write: got %0h want 6906", {log_addr[pass_base+74], log_data[pass_base+74]});
    end
    tests_run++;
    if (bus.o_rom_addr !== 8'd76) begin tests_failed++; $display("FAIL end_rom_addr: got %0d want 76", bus.o_rom_addr); end
    tests_run++;
    if ({bus.o_done, bus.o_busy} !== 2'b10) begin tests_failed++; $display("FAIL end_done_busy: got %b want 10", {bus.o_done, bus.o_busy}); end
    tests_run++;
    if (busy_gap !== gap0) begin tests_failed++; $display("FAIL done_busy_together: got %0d violations want 0", busy_gap - gap0); end
    tests_run++;
    if (dbl_pulse !== 0 || unstable !== 0) begin tests_failed++; $display("FAIL pulse_and_hold: got %0d/%0d want 0/0", dbl_pulse, unstable); end
  endtask

  task automatic test_delay_timing();
    // ready rises in cycle R; write 2 (log index 1) starts at R + 10 delay + 3 + 3
    tests_run++;
    if (start_cyc[pass_base+1] - rise_cyc[pass_base] !== 16) begin
      tests_failed++; $display("FAIL delay_gap: got %0d cycles want 16", start_cyc[pass_base+1] - rise_cyc[pass_base]);
    end
  endtask

  task automatic test_ready_stall();
    bit ok;
    int base;
    int rel;
    base = n_wr;
    force_low = 1'b1;
    @(negedge clk); bus.i_start = 1'b1;
    @(negedge clk); bus.i_start = 1'b0;
    repeat (8) @(negedge clk);
    tests_run++;
    if (n_wr !== base) begin tests_failed++; $display("FAIL stall_no_start: got %0d writes want 0", n_wr - base); end
    force_low = 1'b0;
    rel = cyc;
    wait_writes(base + 1, 20, ok);
    tests_run++;
    if (ok !== 1'b1 || start_cyc[base] !== rel + 1) begin
      tests_failed++; $display("FAIL stall_release: got start cycle %0d want %0d", start_cyc[base], rel + 1);
    end
    wait_done(3000, ok);
    tests_run++;
    if (ok !== 1'b1 || n_wr - base !== 75) begin tests_failed++; $display("FAIL stall_pass: got %0d writes want 75", n_wr - base); end
    tests_run++;
    if (dbl_pulse !== 0 || unstable !== 0) begin tests_failed++; $display("FAIL stall_hold: got %0d/%0d want 0/0", dbl_pulse, unstable); end
  endtask

  task automatic test_start_while_busy();
    bit ok;
    int base;
    base = n_wr;
    pulse_start();
    wait_writes(base + 5, 500, ok);
    pulse_start();
    tests_run++;
    if (ok !== 1'b1 || {bus.o_busy, bus.o_rom_addr} !== {1'b1, 8'd5} || n_wr !== base + 5) begin
      tests_failed++; $display("FAIL busy_start_ignored: got busy=%b addr=%0d writes=%0d want 1/5/5", bus.o_busy, bus.o_rom_addr, n_wr - base);
    end
    wait_done(3000, ok);
    tests_run++;
    if (ok !== 1'b1 || n_wr - base !== 75 || seq_mismatches(base) !== 0) begin
      tests_failed++; $display("FAIL busy_pass: got %0d writes, %0d mismatches want 75/0", n_wr - base, seq_mismatches(base));
    end
    base = n_wr;
    pulse_start();
    tests_run++;
    if ({bus.o_done, bus.o_busy, bus.o_rom_addr} !== {1'b0, 1'b1, 8'd0}) begin
      tests_failed++; $display("FAIL restart: got done=%b busy=%b addr=%0d want 0/1/0", bus.o_done, bus.o_busy, bus.o_rom_addr);
    end
    wait_done(3000, ok);
    tests_run++;
    if (ok !== 1'b1 || n_wr - base !== 75 || seq_mismatches(base) !== 0) begin
      tests_failed++; $display("FAIL second_pass: got %0d writes, %0d mismatches want 75/0", n_wr - base, seq_mismatches(base));
    end
  endtask

  task automatic test_reset_abort();
    bit ok;
    int base;
    base = n_wr;
    pulse_start();
    wait_writes(base + 1, 50, ok);
    repeat (8) @(negedge clk);
    tests_run++;
    if (ok !== 1'b1 || bus.o_rom_addr !== 8'd1 || bus.o_busy !== 1'b1) begin
      tests_failed++; $display("FAIL pre_delay_reset: got addr=%0d busy=%b want 1/1", bus.o_rom_addr, bus.o_busy);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr, bus.o_sccb_addr, bus.o_sccb_data} !== 27'h0) begin
      tests_failed++; $display("FAIL delay_reset: got %0h want 0", {bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr, bus.o_sccb_addr, bus.o_sccb_data});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    base = n_wr;
    pulse_start();
    wait_writes(base + 1, 50, ok);
    @(negedge clk);
    tests_run++;
    if (ok !== 1'b1 || bus.o_sccb_addr !== 8'h12 || bus.i_sccb_ready !== 1'b0) begin
      tests_failed++; $display("FAIL pre_wait_reset: got sccb_addr=%0h ready=%b want 12/0", bus.o_sccb_addr, bus.i_sccb_ready);
    end
    #2 rst = 1'b1;
    #1;
    tests_run++;
    if ({bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr, bus.o_sccb_addr, bus.o_sccb_data} !== 27'h0) begin
      tests_failed++; $display("FAIL wait_reset: got %0h want 0", {bus.o_busy, bus.o_done, bus.o_sccb_start, bus.o_rom_addr, bus.o_sccb_addr, bus.o_sccb_data});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    base = n_wr;
    pulse_start();
    wait_done(3000, ok);
    tests_run++;
    if (ok !== 1'b1 || n_wr - base !== 75 || seq_mismatches(base) !== 0) begin
      tests_failed++; $display("FAIL post_reset_pass: got %0d writes, %0d mismatches want 75/0", n_wr - base, seq_mismatches(base));
    end
  endtask

  task automatic test_unterminated();
    bit ok;
    int base;
    int bad;
    for (int i = 0; i < 256; i++) rom[i] = 16'h0155;
    base = n_wr;
    pulse_start();
    wait_done(4000, ok);
    tests_run++;
    if (ok !== 1'b1 || n_wr - base !== 256) begin tests_failed++; $display("FAIL unterm_count: got %0d writes want 256", n_wr - base); end
    bad = 0;
    for (int k = 0; k < 256; k++) if ({log_addr[base+k], log_data[base+k]} !== 16'h0155) bad++;
    tests_run++;
    if (bad !== 0) begin tests_failed++; $display("FAIL unterm_data: got %0d bad writes want 0", bad); end
    repeat (20) @(negedge clk);
    tests_run++;
    if ({bus.o_done, bus.o_busy, bus.o_rom_addr} !== {1'b1, 1'b0, 8'hFF} || n_wr - base !== 256) begin
      tests_failed++; $display("FAIL unterm_no_wrap: got done=%b busy=%b addr=%0h writes=%0d want 1/0/ff/256", bus.o_done, bus.o_busy, bus.o_rom_addr, n_wr - base);
    end
  endtask

  initial begin
    bus.i_start = 1'b0;
    test_reset();
    test_full_table();
    test_delay_timing();
    test_ready_stall();
    test_start_while_busy();
    test_reset_abort();
    test_unterminated();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
